// File: rtl/router_pkg.sv
// Shared width helpers for the buffered router: select, payload and FIFO count widths.
package router_pkg;

  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int pay_w(input int nbits, input int n);
    return nbits - sel_w(n);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Single-lane FIFO: synchronous push/pop, asynchronous reset of pointers and count.
// Storage is not reset; only the control state is.
module router_fifo
  import router_pkg::*;
#(
  parameter int p_width = 6,
  parameter int p_depth = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [p_width-1:0]          wdata,
  output logic [p_width-1:0]          head,
  output logic [cnt_w(p_depth)-1:0]   count,
  output logic                        empty,
  output logic                        full
);

  localparam int AW = $clog2(p_depth);
  localparam int CW = cnt_w(p_depth);

  logic [p_width-1:0] mem [p_depth];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(p_depth));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/buffered_router.sv
// 1-to-N packet router: top select bits pick a lane, payload is queued in that lane's FIFO.
// Optional ROUTER_BYPASS_EN forwards a packet combinationally to an empty, ready lane.
module buffered_router
  import router_pkg::*;
#(
  parameter int p_nbits    = 32,
  parameter int p_noutputs = 4,
  parameter int p_depth    = 4
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             valid_in,
  output logic                                             ready_out,
  input  logic [p_nbits-1:0]                               message_in,
  output logic [p_noutputs-1:0]                            valid_out,
  input  logic [p_noutputs-1:0]                            ready_in,
  output logic [p_noutputs*pay_w(p_nbits,p_noutputs)-1:0]  message_out,
  output logic                                             drop
);

  localparam int SELW = sel_w(p_noutputs);
  localparam int PW   = pay_w(p_nbits, p_noutputs);
  localparam int CW   = cnt_w(p_depth);

  logic [SELW-1:0]       sel;
  logic [PW-1:0]         payload;
  logic                  sel_ok;
  logic                  has_room;
  logic                  accept;
  logic [p_noutputs-1:0] hit;
  logic [p_noutputs-1:0] bypass;
  logic [p_noutputs-1:0] push;
  logic [p_noutputs-1:0] pop;
  logic [p_noutputs-1:0] empty;
  logic [p_noutputs-1:0] full;
  logic [PW-1:0]         head_arr [p_noutputs];
  logic [CW-1:0]         cnt_arr  [p_noutputs];
  logic                  drop_p1;

  assign sel     = message_in[p_nbits-1 -: SELW];
  assign payload = message_in[PW-1:0];

  // Input decode: ready depends only on the selected lane's occupancy, never on ready_in.
  always_comb begin
    sel_ok   = int'(sel) < p_noutputs;
    has_room = 1'b1;
    hit      = '0;
    for (int i = 0; i < p_noutputs; i++) begin
      if (int'(sel) == i) begin
        hit[i]   = 1'b1;
        has_room = cnt_arr[i] < CW'(p_depth);
      end
    end
    ready_out = !reset && (!sel_ok || has_room);
    accept    = valid_in && ready_out;
  end

  // Output side: a queued head always wins over a bypassed packet.
  always_comb begin
    bypass      = '0;
    push        = '0;
    pop         = '0;
    valid_out   = '0;
    message_out = '0;
    for (int i = 0; i < p_noutputs; i++) begin
`ifdef ROUTER_BYPASS_EN
      bypass[i] = accept && hit[i] && empty[i] && ready_in[i];
`else
      bypass[i] = 1'b0;
`endif
      push[i]      = accept && hit[i] && !bypass[i] && !full[i];
      pop[i]       = !empty[i] && ready_in[i];
      valid_out[i] = !empty[i] || bypass[i];
      if (!empty[i])
        message_out[i*PW +: PW] = head_arr[i];
      else if (bypass[i])
        message_out[i*PW +: PW] = payload;
    end
  end

  for (genvar g = 0; g < p_noutputs; g++) begin : g_lane
    router_fifo #(
      .p_width (PW),
      .p_depth (p_depth)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[g]),
      .pop   (pop[g]),
      .wdata (payload),
      .head  (head_arr[g]),
      .count (cnt_arr[g]),
      .empty (empty[g]),
      .full  (full[g])
    );
  end

  // Drop flag stage: pulses the cycle after an invalid-select transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_p1 <= 1'b0;
    else       drop_p1 <= accept && !sel_ok;
  end

  assign drop = drop_p1;

endmodule

// File: tb/tb_buffered_router.sv
// Directed bench for buffered_router (8-bit packets, 4 lanes, depth 4, plus a 3-lane instance).
// Expectations follow ROUTER_BYPASS_EN when the bench is built with that macro.
module tb_buffered_router;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  message_in;
  logic [3:0]  valid_out;
  logic [3:0]  ready_in;
  logic [23:0] message_out;
  logic        drop;

  logic        v3;
  logic        r3;
  logic [7:0]  m3;
  logic [2:0]  vo3;
  logic [2:0]  ri3;
  logic [17:0] mo3;
  logic        drop3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  buffered_router #(.p_nbits(8), .p_noutputs(4), .p_depth(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .message_in(message_in), .valid_out(valid_out), .ready_in(ready_in),
    .message_out(message_out), .drop(drop)
  );

  buffered_router #(.p_nbits(8), .p_noutputs(3), .p_depth(4)) dut3 (
    .clk(clk), .reset(reset), .valid_in(v3), .ready_out(r3),
    .message_in(m3), .valid_out(vo3), .ready_in(ri3),
    .message_out(mo3), .drop(drop3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ready_in = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      valid_in   = 1'b1;
      message_in = {2'b00, 6'(k)};
      step();
    end
    valid_in = 1'b0;
    #1;
    tests++; if (valid_out !== 4'b0001) begin fails++; $display("FAIL rst_preload valid_out got %b want 0001", valid_out); end
    reset      = 1'b1;
    valid_in   = 1'b1;
    message_in = 8'h07;
    #1;
    tests++; if (valid_out !== 4'b0000) begin fails++; $display("FAIL rst_valid_out got %b want 0000", valid_out); end
    tests++; if (ready_out !== 1'b0) begin fails++; $display("FAIL rst_ready_out got %b want 0", ready_out); end
    tests++; if (message_out !== 24'h0) begin fails++; $display("FAIL rst_message_out got %h want 000000", message_out); end
    step();
    tests++; if (drop !== 1'b0 || ready_out !== 1'b0) begin fails++; $display("FAIL rst_hold drop/ready got %b%b want 00", drop, ready_out); end
    valid_in = 1'b0;
    reset    = 1'b0;
    #1;
    tests++; if (ready_out !== 1'b1) begin fails++; $display("FAIL rst_release ready_out got %b want 1", ready_out); end
    step();
    tests++; if (valid_out !== 4'b0000) begin fails++; $display("FAIL rst_lane0_empty valid_out got %b want 0000", valid_out); end
  endtask

  task automatic test_route();
    ready_in   = 4'b1111;
    valid_in   = 1'b1;
    message_in = 8'hAA;
    #1;
`ifdef ROUTER_BYPASS_EN
    tests++; if (valid_out !== 4'b0100 || message_out[17:12] !== 6'h2A) begin fails++; $display("FAIL route_same valid/msg got %b/%h want 0100/2a", valid_out, message_out[17:12]); end
    step();
    valid_in = 1'b0;
    #1;
    tests++; if (valid_out !== 4'b0000) begin fails++; $display("FAIL route_next valid_out got %b want 0000", valid_out); end
`else
    tests++; if (valid_out !== 4'b0000) begin fails++; $display("FAIL route_same valid_out got %b want 0000", valid_out); end
    step();
    valid_in = 1'b0;
    #1;
    tests++; if (valid_out !== 4'b0100 || message_out[17:12] !== 6'h2A) begin fails++; $display("FAIL route_next valid/msg got %b/%h want 0100/2a", valid_out, message_out[17:12]); end
    step();
    tests++; if (valid_out !== 4'b0000) begin fails++; $display("FAIL route_once valid_out got %b want 0000", valid_out); end
`endif
  endtask

  task automatic test_hol();
    ready_in = 4'b1101;
    for (int k = 1; k <= 4; k++) begin
      valid_in   = 1'b1;
      message_in = {2'b01, 6'(k)};
      #1;
      tests++; if (ready_out !== 1'b1) begin fails++; $display("FAIL hol_fill%0d ready_out got %b want 1", k, ready_out); end
      step();
    end
    message_in = {2'b01, 6'd5};
    #1;
    tests++; if (ready_out !== 1'b0) begin fails++; $display("FAIL hol_full ready_out got %b want 0", ready_out); end
    tests++; if (message_out[11:6] !== 6'd1) begin fails++; $display("FAIL hol_head1 got %h want 01", message_out[11:6]); end
    step();
    tests++; if (ready_out !== 1'b0) begin fails++; $display("FAIL hol_stall ready_out got %b want 0", ready_out); end
    ready_in = 4'b1111;
    #1;
    tests++; if (ready_out !== 1'b0) begin fails++; $display("FAIL hol_nopass ready_out got %b want 0", ready_out); end
    step();
    tests++; if (ready_out !== 1'b1 || message_out[11:6] !== 6'd2) begin fails++; $display("FAIL hol_pop1 ready/head got %b/%h want 1/02", ready_out, message_out[11:6]); end
    step();
    message_in = 8'h3C;
    #1;
    tests++; if (message_out[11:6] !== 6'd3) begin fails++; $display("FAIL hol_pop2 head got %h want 03", message_out[11:6]); end
`ifdef ROUTER_BYPASS_EN
    tests++; if (valid_out[0] !== 1'b1 || message_out[5:0] !== 6'h3C) begin fails++; $display("FAIL hol_lane0_byp valid/msg got %b/%h want 1/3c", valid_out[0], message_out[5:0]); end
`endif
    step();
    valid_in = 1'b0;
    #1;
    tests++; if (message_out[11:6] !== 6'd4) begin fails++; $display("FAIL hol_pop3 head got %h want 04", message_out[11:6]); end
`ifndef ROUTER_BYPASS_EN
    tests++; if (valid_out[0] !== 1'b1 || message_out[5:0] !== 6'h3C) begin fails++; $display("FAIL hol_lane0 valid/msg got %b/%h want 1/3c", valid_out[0], message_out[5:0]); end
`endif
    step();
    tests++; if (valid_out !== 4'b0010 || message_out[11:6] !== 6'd5) begin fails++; $display("FAIL hol_fifth valid/head got %b/%h want 0010/05", valid_out, message_out[11:6]); end
    step();
    tests++; if (valid_out !== 4'b0000) begin fails++; $display("FAIL hol_drained valid_out got %b want 0000", valid_out); end
  endtask

  task automatic test_full_pop();
    ready_in = 4'b0111;
    for (int k = 1; k <= 4; k++) begin
      valid_in   = 1'b1;
      message_in = {2'b11, 6'(16 + k)};
      step();
    end
    message_in = {2'b11, 6'h15};
    ready_in   = 4'b1111;
    #1;
    tests++; if (ready_out !== 1'b0) begin fails++; $display("FAIL fullpop_ready got %b want 0", ready_out); end
    tests++; if (message_out[23:18] !== 6'h11) begin fails++; $display("FAIL fullpop_head got %h want 11", message_out[23:18]); end
    step();
    tests++; if (ready_out !== 1'b1 || message_out[23:18] !== 6'h12) begin fails++; $display("FAIL fullpop_after ready/head got %b/%h want 1/12", ready_out, message_out[23:18]); end
    step();
    valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (valid_out[3] !== 1'b1 || message_out[23:18] !== 6'(8'h13 + k)) begin fails++; $display("FAIL fullpop_drain%0d valid/head got %b/%h want 1/%h", k, valid_out[3], message_out[23:18], 8'h13 + k); end
      step();
    end
    tests++; if (valid_out !== 4'b0000) begin fails++; $display("FAIL fullpop_empty valid_out got %b want 0000", valid_out); end
  endtask

  task automatic test_invalid_select();
    ri3 = 3'b111;
    v3  = 1'b1;
    m3  = 8'hC5;
    #1;
    tests++; if (r3 !== 1'b1 || drop3 !== 1'b0) begin fails++; $display("FAIL inv_accept ready/drop got %b/%b want 1/0", r3, drop3); end
    step();
    v3 = 1'b0;
    #1;
    tests++; if (drop3 !== 1'b1 || vo3 !== 3'b000) begin fails++; $display("FAIL inv_drop drop/valid got %b/%b want 1/000", drop3, vo3); end
    step();
    tests++; if (drop3 !== 1'b0 || vo3 !== 3'b000) begin fails++; $display("FAIL inv_pulse drop/valid got %b/%b want 0/000", drop3, vo3); end
    m3 = 8'h85;
    #1;
    tests++; if (r3 !== 1'b1) begin fails++; $display("FAIL inv_lane2_room ready got %b want 1", r3); end
  endtask

  task automatic test_bypass();
    ready_in   = 4'b1111;
    valid_in   = 1'b1;
    message_in = 8'h15;
    #1;
`ifdef ROUTER_BYPASS_EN
    tests++; if (valid_out !== 4'b0001 || message_out[5:0] !== 6'h15 || ready_out !== 1'b1) begin fails++; $display("FAIL byp_same valid/msg/ready got %b/%h/%b want 0001/15/1", valid_out, message_out[5:0], ready_out); end
    step();
    valid_in = 1'b0;
    #1;
    tests++; if (valid_out !== 4'b0000) begin fails++; $display("FAIL byp_not_queued valid_out got %b want 0000", valid_out); end
`else
    tests++; if (valid_out !== 4'b0000) begin fails++; $display("FAIL lat_same valid_out got %b want 0000", valid_out); end
    step();
    valid_in = 1'b0;
    #1;
    tests++; if (valid_out !== 4'b0001 || message_out[5:0] !== 6'h15) begin fails++; $display("FAIL lat_next valid/msg got %b/%h want 0001/15", valid_out, message_out[5:0]); end
    step();
    tests++; if (valid_out !== 4'b0000) begin fails++; $display("FAIL lat_popped valid_out got %b want 0000", valid_out); end
`endif
  endtask

  initial begin
    reset      = 1'b1;
    valid_in   = 1'b0;
    message_in = 8'h00;
    ready_in   = 4'b0000;
    v3         = 1'b0;
    m3         = 8'h00;
    ri3        = 3'b000;
    step();
    step();
    reset = 1'b0;
    step();
    test_reset();
    test_route();
    test_hol();
    test_full_pop();
    test_invalid_select();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
